// File: rtl/i2c_slave_regfile_if.sv
// Pad and host-side signals of the I2C register-file target.
// The slave modport is the target's view; master is the SoC/pad/bench side.
interface i2c_slave_regfile_if #(
    parameter int PTR_W = 4
);
    logic             scl_i;
    logic             sda_i;
    logic             sda_oe;
    logic             host_we;
    logic [PTR_W-1:0] host_addr;
    logic [7:0]       host_wdata;
    logic [7:0]       host_rdata;
    logic             wr_strobe;
    logic [PTR_W-1:0] wr_addr;
    logic [7:0]       wr_data;
    logic             busy;

    modport slave (
        input  scl_i, sda_i, host_we, host_addr, host_wdata,
        output sda_oe, host_rdata, wr_strobe, wr_addr, wr_data, busy
    );

    modport master (
        output scl_i, sda_i, host_we, host_addr, host_wdata,
        input  sda_oe, host_rdata, wr_strobe, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/i2c_slave_regfile.sv
// Oversampling I2C target with an auto-incrementing byte register file.
// SCL/SDA are synchronised to clk; every bus event is a one-clk strobe.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h2A,
    parameter int         DEPTH       = 16,
    parameter int         SYNC_STAGES = 2
) (
    input logic                clk,
    input logic                rst_n,
    i2c_slave_regfile_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic                   scl, sda;
    logic                   start_det, stop_det, scl_rise, scl_fall, byte_done;

    state_t           state;
    logic [7:0]       regs [DEPTH];
    logic [7:0]       shift;
    logic [7:0]       rx_byte;
    logic [2:0]       cnt;
    logic [PTR_W-1:0] ptr;
    logic             rw;

    // Synchronisers idle high so a reset never fabricates a START/STOP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
            scl_d    <= scl;
            sda_d    <= sda;
        end
    end

    assign scl       = scl_sync[SYNC_STAGES-1];
    assign sda       = sda_sync[SYNC_STAGES-1];
    assign start_det = scl & sda_d & ~sda;
    assign stop_det  = scl & ~sda_d & sda;
    // An SCL edge landing on a START/STOP clk is not a data edge.
    assign scl_rise  = scl & ~scl_d & ~(start_det | stop_det);
    assign scl_fall  = ~scl & scl_d & ~(start_det | stop_det);
    assign byte_done = scl_rise && (cnt == 3'd0);
    assign rx_byte   = {shift[6:0], sda};

    assign bus.host_rdata = regs[bus.host_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            shift         <= 8'h00;
            cnt           <= 3'd7;
            ptr           <= '0;
            rw            <= 1'b0;
            bus.sda_oe    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.wr_strobe <= 1'b0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= 8'h00;
            for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
        end else begin
            bus.wr_strobe <= 1'b0;
            // Host write sits first so a same-clk I2C write to that address wins.
            if (bus.host_we) regs[bus.host_addr] <= bus.host_wdata;

            if (start_det) begin
                state      <= ADDR;
                cnt        <= 3'd7;
                bus.sda_oe <= 1'b0;
            end else if (stop_det) begin
                state      <= IDLE;
                bus.busy   <= 1'b0;
                bus.sda_oe <= 1'b0;
            end else begin
                if (scl_rise) begin
                    shift <= rx_byte;
                    cnt   <= cnt - 3'd1;
                end
                if (scl_fall) bus.sda_oe <= 1'b0;

                case (state)
                    ADDR: begin
                        if (byte_done) begin
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state    <= ADDR_ACK;
                                bus.busy <= 1'b1;
                                rw       <= rx_byte[0];
                            end else begin
                                state    <= IDLE;
                                bus.busy <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) bus.sda_oe <= 1'b1;
                        if (scl_rise) begin
                            cnt <= 3'd7;
                            if (rw) begin
                                state <= RD_DATA;
                                shift <= regs[ptr];
                            end else begin
                                state <= PTR;
                            end
                        end
                    end
                    PTR: begin
                        if (byte_done) begin
                            ptr   <= rx_byte[PTR_W-1:0];
                            state <= PTR_ACK;
                        end
                    end
                    PTR_ACK, WR_ACK: begin
                        if (scl_fall) bus.sda_oe <= 1'b1;
                        if (scl_rise) begin
                            cnt   <= 3'd7;
                            state <= WR_DATA;
                        end
                    end
                    WR_DATA: begin
                        if (byte_done) begin
                            regs[ptr]     <= rx_byte;
                            bus.wr_strobe <= 1'b1;
                            bus.wr_addr   <= ptr;
                            bus.wr_data   <= rx_byte;
                            ptr           <= ptr + 1'b1;
                            state         <= WR_ACK;
                        end
                    end
                    RD_DATA: begin
                        // The ninth fall of the previous slot presents the MSB.
                        if (scl_fall) bus.sda_oe <= ~shift[7];
                        if (byte_done) begin
                            ptr   <= ptr + 1'b1;
                            state <= RD_ACK;
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            cnt <= 3'd7;
                            if (!sda) begin
                                state <= RD_DATA;
                                shift <= regs[ptr];
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
